// File: rtl/frame_pixel_writer.sv
// Pixel-plot sink: clips off-screen pixels, buffers accepted ones in a small FIFO
// and commits them to the 160x120 framebuffer, with a flush handshake for the sequencer.
module frame_pixel_writer #(
    parameter int SCREEN_W    = 160,
    parameter int SCREEN_H    = 120,
    parameter int COLOR_DEPTH = 9,
    parameter int FIFO_DEPTH  = 8,
    parameter int ADDR_WIDTH  = 15
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [7:0]             x,
    input  logic [6:0]             y,
    input  logic [COLOR_DEPTH-1:0] color,
    input  logic                   plot,
    output logic                   ready,
    input  logic                   fb_busy,
    output logic [ADDR_WIDTH-1:0]  fb_address,
    output logic [COLOR_DEPTH-1:0] fb_data,
    output logic                   fb_wren,
    input  logic                   flush_req,
    output logic                   flush_done,
    output logic [7:0]             clip_count,
    output logic                   overflow,
    input  logic                   clear_status
);

    // Handshake: a pixel is taken on an edge with plot=1 and ready=1; plot while
    // ready=0 drops the pixel (sets overflow). There is no backpressure on the
    // drawing engines beyond ready, and off-screen pixels are always consumed.

    localparam int ENTRY_W = 8 + 7 + COLOR_DEPTH;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam logic [7:0] X_LIM = 8'(SCREEN_W);
    localparam logic [6:0] Y_LIM = 7'(SCREEN_H);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    logic [ENTRY_W-1:0]     mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [ADDR_WIDTH-1:0]  fb_address_q, fb_address_d;
    logic [COLOR_DEPTH-1:0] fb_data_q, fb_data_d;
    logic                   fb_wren_q, fb_wren_d;
    logic [7:0]             clip_count_q, clip_count_d;
    logic                   overflow_q, overflow_d;
    state_t                 state_q, state_d;

    logic                   in_range;
    logic                   push;
    logic                   pop;
    logic [ENTRY_W-1:0]     head;
    logic [7:0]             head_x;
    logic [6:0]             head_y;
    logic [COLOR_DEPTH-1:0] head_color;
    logic [ADDR_WIDTH-1:0]  head_y_w;

    assign head       = mem_q[rd_ptr_q];
    assign head_x     = head[ENTRY_W-1 -: 8];
    assign head_y     = head[COLOR_DEPTH +: 7];
    assign head_color = head[COLOR_DEPTH-1:0];
    assign head_y_w   = ADDR_WIDTH'(head_y);

    always_comb begin
        in_range     = (x < X_LIM) && (y < Y_LIM);
        ready        = (count_q != FULL_CNT);
        push         = plot && in_range && ready;
        pop          = (count_q != '0) && !fb_busy;

        wr_ptr_d     = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d     = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d      = count_q + CNT_W'(push) - CNT_W'(pop);

        // y*160 + x as two shifts and an add
        fb_address_d = pop ? (head_y_w << 7) + (head_y_w << 5) + ADDR_WIDTH'(head_x)
                           : fb_address_q;
        fb_data_d    = pop ? head_color : fb_data_q;
        fb_wren_d    = pop;

        clip_count_d = clip_count_q;
        overflow_d   = overflow_q;
        if (clear_status) begin
            clip_count_d = '0;
            overflow_d   = 1'b0;
        end else begin
            if (plot && !in_range && clip_count_q != 8'hFF)
                clip_count_d = clip_count_q + 8'd1;
            if (plot && in_range && !ready)
                overflow_d = 1'b1;
        end
    end

    // A push on the same edge would leave an unwritten pixel, so it blocks leaving DRAIN
    always_comb begin
        state_d    = state_q;
        flush_done = 1'b0;
        case (state_q)
            ST_IDLE:  if (flush_req) state_d = ST_DRAIN;
            ST_DRAIN: if (count_q == '0 && !pop && !push) state_d = ST_DONE;
            ST_DONE: begin
                flush_done = 1'b1;
                state_d    = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            fb_address_q <= '0;
            fb_data_q    <= '0;
            fb_wren_q    <= 1'b0;
            clip_count_q <= '0;
            overflow_q   <= 1'b0;
            state_q      <= ST_IDLE;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            fb_address_q <= fb_address_d;
            fb_data_q    <= fb_data_d;
            fb_wren_q    <= fb_wren_d;
            clip_count_q <= clip_count_d;
            overflow_q   <= overflow_d;
            state_q      <= state_d;
        end
    end

    // Storage needs no reset: occupancy and pointers define which entries are live
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= {x, y, color};
    end

    assign fb_address = fb_address_q;
    assign fb_data    = fb_data_q;
    assign fb_wren    = fb_wren_q;
    assign clip_count = clip_count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_frame_pixel_writer.sv
// Self-checking bench for frame_pixel_writer: scenario tasks plus a write scoreboard.
module tb_frame_pixel_writer;

    logic        clock = 1'b0;
    logic        resetn;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [8:0]  color;
    logic        plot;
    logic        ready;
    logic        fb_busy;
    logic [14:0] fb_address;
    logic [8:0]  fb_data;
    logic        fb_wren;
    logic        flush_req;
    logic        flush_done;
    logic [7:0]  clip_count;
    logic        overflow;
    logic        clear_status;

    int total = 0;
    int bad   = 0;
    logic [23:0] exp_q[$];
    logic [23:0] mon_exp;

    frame_pixel_writer dut (
        .clock        (clock),
        .resetn       (resetn),
        .x            (x),
        .y            (y),
        .color        (color),
        .plot         (plot),
        .ready        (ready),
        .fb_busy      (fb_busy),
        .fb_address   (fb_address),
        .fb_data      (fb_data),
        .fb_wren      (fb_wren),
        .flush_req    (flush_req),
        .flush_done   (flush_done),
        .clip_count   (clip_count),
        .overflow     (overflow),
        .clear_status (clear_status)
    );

    always #5 clock = ~clock;

    // Scoreboard: every observed write must match the oldest expected pixel
    always @(negedge clock) begin
        if (resetn && fb_wren) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL stale_write: got addr=%0d data=%h, no write expected", fb_address, fb_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({fb_address, fb_data} !== mon_exp) begin
                    bad++;
                    $display("FAIL write_data: got addr=%0d data=%h, want addr=%0d data=%h",
                             fb_address, fb_data, mon_exp[23:9], mon_exp[8:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_pixel(input int px, input int py, input int pc, input bit expect_write);
        int addr;
        x     = 8'(px);
        y     = 7'(py);
        color = 9'(pc);
        plot  = 1'b1;
        if (expect_write) begin
            addr = py * 160 + px;
            exp_q.push_back({15'(addr), 9'(pc)});
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; plot = 1'b0; fb_busy = 1'b0; flush_req = 1'b0; clear_status = 1'b0;
        x = '0; y = '0; color = '0;
        #3;
        total++;
        if ({ready, fb_wren, fb_address, fb_data, flush_done, clip_count, overflow} !==
            {1'b1, 1'b0, 15'd0, 9'd0, 1'b0, 8'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state: ready=%b wren=%b addr=%0d data=%h done=%b clip=%0d ovf=%b",
                     ready, fb_wren, fb_address, fb_data, flush_done, clip_count, overflow);
        end
        tick();
        tick();
        resetn = 1'b1;
    endtask

    task automatic test_latency();
        drive_pixel(10, 5, 'h1AB, 1'b1);
        tick();
        plot = 1'b0;
        total++;
        if (fb_wren !== 1'b0) begin
            bad++; $display("FAIL latency_early: wren=%b want 0", fb_wren);
        end
        tick();
        total++;
        if ({fb_wren, fb_address, fb_data} !== {1'b1, 15'd810, 9'h1AB}) begin
            bad++; $display("FAIL latency_write: wren=%b addr=%0d data=%h want 1 810 1ab", fb_wren, fb_address, fb_data);
        end
        tick();
        total++;
        if ({fb_wren, fb_address} !== {1'b0, 15'd810}) begin
            bad++; $display("FAIL latency_hold: wren=%b addr=%0d want 0 810", fb_wren, fb_address);
        end
    endtask

    task automatic test_clip();
        drive_pixel(159, 119, 'h055, 1'b1);
        tick();
        drive_pixel(160, 0, 'h011, 1'b0);
        tick();
        drive_pixel(0, 120, 'h022, 1'b0);
        tick();
        plot = 1'b0;
        tick();
        tick();
        total++;
        if ({clip_count, overflow} !== {8'd2, 1'b0}) begin
            bad++; $display("FAIL clip_count: clip=%0d ovf=%b want 2 0", clip_count, overflow);
        end
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
        total++;
        if (clip_count !== 8'd0) begin
            bad++; $display("FAIL clip_clear: clip=%0d want 0", clip_count);
        end
        // clear and a clipped pixel on the same edge: clear wins
        clear_status = 1'b1;
        drive_pixel(200, 5, 'h0, 1'b0);
        tick();
        clear_status = 1'b0;
        plot = 1'b0;
        total++;
        if (clip_count !== 8'd0) begin
            bad++; $display("FAIL clear_priority: clip=%0d want 0", clip_count);
        end
        for (int i = 0; i < 260; i++) begin
            drive_pixel($urandom_range(160, 255), $urandom_range(0, 127), $urandom_range(0, 511), 1'b0);
            tick();
        end
        plot = 1'b0;
        total++;
        if ({clip_count, overflow} !== {8'd255, 1'b0}) begin
            bad++; $display("FAIL clip_saturate: clip=%0d ovf=%b want 255 0", clip_count, overflow);
        end
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
    endtask

    task automatic test_overflow();
        fb_busy = 1'b1;
        for (int i = 0; i < 9; i++) begin
            drive_pixel(i * 17, i * 13, i * 50 + 3, i < 8);
            tick();
            if (i == 7) begin
                total++;
                if (ready !== 1'b0) begin
                    bad++; $display("FAIL full_ready: ready=%b want 0", ready);
                end
            end
        end
        plot = 1'b0;
        total++;
        if (overflow !== 1'b1) begin
            bad++; $display("FAIL overflow_set: ovf=%b want 1", overflow);
        end
        fb_busy = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            total++;
            if (fb_wren !== 1'b1) begin
                bad++; $display("FAIL drain_wren[%0d]: wren=%b want 1", k, fb_wren);
            end
        end
        tick();
        total++;
        if ({fb_wren, ready} !== 2'b01) begin
            bad++; $display("FAIL drain_end: wren=%b ready=%b want 0 1", fb_wren, ready);
        end
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic exp_w;
        for (int c = 0; c < 22; c++) begin
            if (c < 20) drive_pixel($urandom_range(0, 159), $urandom_range(0, 119), $urandom_range(0, 511), 1'b1);
            else plot = 1'b0;
            tick();
            exp_w = (c >= 1 && c <= 20);
            total++;
            if ({ready, fb_wren} !== {1'b1, exp_w}) begin
                bad++; $display("FAIL stream[%0d]: ready=%b wren=%b want 1 %b", c, ready, fb_wren, exp_w);
            end
        end
    endtask

    task automatic test_flush();
        int writes = 0;
        int last_c = -100;
        int done_n = 0;
        int done_c = -1;
        fb_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_pixel($urandom_range(0, 159), $urandom_range(0, 119), $urandom_range(0, 511), 1'b1);
            tick();
        end
        plot = 1'b0;
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (c == 3) fb_busy = 1'b0;
            tick();
            if (fb_wren === 1'b1) begin
                writes++;
                if (writes == 5) last_c = c;
            end
            if (flush_done === 1'b1) begin
                done_n++;
                done_c = c;
            end
        end
        total++;
        if ({writes, done_n, done_c} !== {32'd5, 32'd1, 32'(last_c + 1)}) begin
            bad++; $display("FAIL flush_drain: writes=%0d pulses=%0d at=%0d want 5 1 %0d", writes, done_n, done_c, last_c + 1);
        end
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        total++;
        if (flush_done !== 1'b0) begin
            bad++; $display("FAIL flush_empty_early: done=%b want 0", flush_done);
        end
        tick();
        total++;
        if (flush_done !== 1'b1) begin
            bad++; $display("FAIL flush_empty_pulse: done=%b want 1", flush_done);
        end
        tick();
        total++;
        if (flush_done !== 1'b0) begin
            bad++; $display("FAIL flush_empty_end: done=%b want 0", flush_done);
        end
    endtask

    task automatic test_reset_mid();
        int stale = 0;
        fb_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_pixel($urandom_range(1, 159), $urandom_range(1, 119), $urandom_range(1, 511), 1'b0);
            tick();
        end
        plot = 1'b0;
        fb_busy = 1'b0;
        tick();
        total++;
        if (fb_wren !== 1'b1) begin
            bad++; $display("FAIL mid_write_active: wren=%b want 1", fb_wren);
        end
        resetn = 1'b0;
        #1;
        total++;
        if ({ready, fb_wren, fb_address, fb_data, flush_done, clip_count, overflow} !==
            {1'b1, 1'b0, 15'd0, 9'd0, 1'b0, 8'd0, 1'b0}) begin
            bad++;
            $display("FAIL mid_reset_state: ready=%b wren=%b addr=%0d data=%h done=%b clip=%0d ovf=%b",
                     ready, fb_wren, fb_address, fb_data, flush_done, clip_count, overflow);
        end
        tick();
        tick();
        resetn = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (fb_wren === 1'b1) stale++;
        end
        total++;
        if ({stale, ready} !== {32'd0, 1'b1}) begin
            bad++; $display("FAIL post_reset: stale_writes=%0d ready=%b want 0 1", stale, ready);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_clip();
        test_overflow();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        for (int c = 0; c < 50 && exp_q.size() != 0; c++) tick();
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL missing_writes: %0d expected writes never seen, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frame_pixel_writer.md
Name: frame_pixel_writer

Overview:
Receiving end of the pixel-plot interface (x, y, color, plot) driven by the background, tile and sprite drawing engines. It clips off-screen pixels and buffers accepted pixels in a small FIFO. It then writes them into the 160x120 framebuffer RAM at address y*160+x, one write per clock whenever the framebuffer port is free. It also provides a flush handshake so the frame sequencer can confirm that all plotted pixels are committed before swapping or starting the next layer.

Parameters:
SCREEN_W, 160, visible width in pixels
SCREEN_H, 120, visible height in pixels
COLOR_DEPTH, 9, bits per pixel colour
FIFO_DEPTH, 8, pixel buffer entries (power of two)
ADDR_WIDTH, 15, framebuffer address width

Ports:
clock  in  1  system clock, all logic on rising edge
resetn  in  1  asynchronous active-low reset
x  in  8  pixel x coordinate
y  in  7  pixel y coordinate
color  in  COLOR_DEPTH  pixel colour
plot  in  1  pixel valid, one pixel per cycle while high
ready  out  1  FIFO can accept a pixel this cycle
fb_busy  in  1  framebuffer write port unavailable this cycle
fb_address  out  ADDR_WIDTH  framebuffer write address
fb_data  out  COLOR_DEPTH  framebuffer write data
fb_wren  out  1  framebuffer write strobe
flush_req  in  1  single-cycle request to drain
flush_done  out  1  single-cycle pulse, drain complete
clip_count  out  8  saturating count of clipped pixels
overflow  out  1  sticky: pixel dropped because FIFO full
clear_status  in  1  clears clip_count and overflow

Behaviour:
- Reset (async, resetn low): FIFO empty. ready=1. fb_wren=0. fb_address=0. fb_data=0. flush_done=0. clip_count=0. overflow=0. FSM=IDLE. Reset mid-write aborts the write and discards buffered pixels.
- Input side:
  - ready = !full, taken from the registered occupancy count.
  - A pixel is sampled on an edge where plot=1.
  - If x>=SCREEN_W or y>=SCREEN_H, it is clipped: not enqueued, clip_count increments and saturates at 255. Clipping applies even when the FIFO is full; it does not set overflow.
  - If in range and ready=1, it is pushed as {x, y, color}.
  - If in range and ready=0, it is dropped and overflow is set to 1.
- Output side:
  - On each edge where the FIFO is non-empty and fb_busy=0, one entry is popped.
  - The same edge registers fb_address = y*160 + x, computed as (y<<7)+(y<<5)+x at ADDR_WIDTH bits. fb_data = color. fb_wren = 1 for the following cycle.
  - Otherwise fb_wren = 0. fb_address and fb_data hold their last values.
- Latency: with the FIFO empty and fb_busy=0, a pixel sampled at edge N produces fb_wren high in the cycle after edge N+1 (2 clocks). Sustained throughput is 1 pixel per clock.
- A simultaneous push and pop is legal whenever ready=1. The occupancy count is unchanged in that case. A push is never accepted while full, even if a pop happens on the same edge.
- fb_busy is sampled only at pop time. A write strobe already issued is never retracted.
- clear_status clears the status on the next edge and has priority over an increment or set on that same edge.
- Flush FSM:
  - IDLE: flush_req=1 -> DRAIN.
  - DRAIN: when the FIFO is empty and no pop is occurring on this edge -> DONE.
  - DONE: flush_done=1 for exactly one cycle -> IDLE.
  - When flush_req arrives with the FIFO already empty, flush_done pulses 2 cycles after the flush_req edge.
  - Pixels plotted during DRAIN are accepted and must also be written before leaving DRAIN.
  - flush_req is ignored outside IDLE.

Test Plan:
1. Reset, then plot (x=10, y=5, color=0x1AB) for one cycle, fb_busy=0 -> 2 clocks later fb_wren=1 for one cycle, fb_address=810, fb_data=0x1AB.
2. Plot (159,119), then (160,0), then (0,120) -> one write at address 19199. clip_count=2, overflow=0. clear_status -> clip_count=0.
3. Hold fb_busy=1 and plot 9 in-range pixels back-to-back -> ready drops after the 8th, the 9th is dropped, overflow=1. Release fb_busy -> 8 consecutive writes in plot order, then ready=1.
4. Stream 20 pixels, one per cycle, with fb_busy=0 -> 20 consecutive fb_wren cycles with correct addresses. ready stays 1.
5. Load 5 pixels with fb_busy=1, then pulse flush_req and release fb_busy 3 cycles later -> flush_done pulses once, only after the 5th write. flush_req with the FIFO empty -> flush_done 2 cycles later.
6. Load 4 pixels, assert resetn=0 mid-drain -> all outputs at reset values immediately. After release there are no stale writes and ready=1.
